// File: rtl/mem_arbiter_2x1.sv
// Round-robin 2:1 arbiter for a native valid/ready memory port with a hung-bus watchdog.
// Latency: s_valid one cycle after grant; master ready is combinational from s_ready; the owner stalls until s_ready or timeout.
module mem_arbiter_2x1 #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              TIMEOUT  = 256,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_valid,
    input  logic                m0_instr,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_valid,
    input  logic                m1_instr,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                s_valid,
    output logic                s_instr,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,

    output logic                grant,
    output logic                busy,
    output logic                timeout_pulse,
    output logic [7:0]          timeout_count
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef struct packed {
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    req_t             req_q;
    req_t             win_req;
    logic             last_grant;
    logic             win;
    logic             any_vld;
    logic             wd_fire;
    logic             done;
    logic [CNT_W-1:0] wd_cnt;
    logic [DATA_W-1:0] rsp_dat;

    // Arbitration: a tie goes to the master that did not win last time.
    always_comb begin
        any_vld = m0_valid | m1_valid;
        win     = (m0_valid && m1_valid) ? ~last_grant : m1_valid;
        win_req = win ? req_t'{m1_instr, m1_addr, m1_wdata, m1_wstrb}
                      : req_t'{m0_instr, m0_addr, m0_wdata, m0_wstrb};
    end

    // A real s_ready in the last watchdog cycle wins over the timeout.
    always_comb begin
        wd_fire = (TIMEOUT > 0) && (state == BUSY) && !s_ready && (wd_cnt == CNT_LAST);
        done    = (state == BUSY) && (s_ready || wd_fire);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_vld) state_nxt = BUSY;
            BUSY: if (done)    state_nxt = IDLE;
            default:           state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q         <= '0;
            s_valid       <= 1'b0;
            busy          <= 1'b0;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            wd_cnt        <= '0;
            timeout_count <= 8'd0;
        end else begin
            if (state == IDLE && any_vld) begin
                req_q      <= win_req;
                s_valid    <= 1'b1;
                busy       <= 1'b1;
                grant      <= win;
                last_grant <= win;
                wd_cnt     <= '0;
            end else if (done) begin
                s_valid    <= 1'b0;
                busy       <= 1'b0;
                wd_cnt     <= '0;
            end else if (state == BUSY) begin
                wd_cnt     <= wd_cnt + 1'b1;
            end
            if (wd_fire && timeout_count != 8'hFF) begin
                timeout_count <= timeout_count + 8'd1;
            end
        end
    end

    assign s_instr       = req_q.instr;
    assign s_addr        = req_q.addr;
    assign s_wdata       = req_q.wdata;
    assign s_wstrb       = req_q.wstrb;
    assign timeout_pulse = wd_fire;

    // Only the owner sees the response; everyone else reads zero.
    assign rsp_dat  = wd_fire ? ERR_DATA : s_rdata;
    assign m0_ready = done && !grant;
    assign m1_ready = done && grant;
    assign m0_rdata = m0_ready ? rsp_dat : '0;
    assign m1_rdata = m1_ready ? rsp_dat : '0;

endmodule
